// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register pending-write (scoreboard) bits.
// Latency: reads combinational; writes/issues/busy_cnt update on rising clk edge.
// Backpressure: none; every wr_en/iss_en is accepted in the cycle presented.
//
// Ports:
//   clk, rst (async active-low)
//   rd_addr1/2 -> rd_data1/2, rd_busy1/2   two combinational read ports
//   wr_en, wr_addr, wr_data                writeback port (clears busy)
//   iss_en, iss_addr                       issue port (sets busy)
//   busy_cnt                               registered popcount of busy bits
//   dbg_addr -> dbg_data                   stored value, never bypassed
// Optional feature: define REGFILE_SB_BYPASS_EN for write-to-read bypass.
module regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [ADDR_W:0]  r_busy_cnt;

    logic w_wr_act;
    logic w_iss_act;
    logic w_set;
    logic w_clr;

    // Register 0 is hardwired: writes and issues to it are dropped here.
    assign w_wr_act  = wr_en  && (wr_addr  != '0);
    assign w_iss_act = iss_en && (iss_addr != '0);

    // Counter tracks only real bit transitions. A write to the address being
    // issued on the same edge does not clear it (issue wins).
    assign w_set = w_iss_act && !r_busy[iss_addr];
    assign w_clr = w_wr_act && r_busy[wr_addr] &&
                   !(w_iss_act && (iss_addr == wr_addr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_act) begin
                r_mem[wr_addr]  <= wr_data;
                r_busy[wr_addr] <= 1'b0;
            end
            // Placed after the write so a same-address issue overrides the clear.
            if (w_iss_act) begin
                r_busy[iss_addr] <= 1'b1;
            end
            r_busy_cnt <= r_busy_cnt + {{ADDR_W{1'b0}}, w_set}
                                     - {{ADDR_W{1'b0}}, w_clr};
        end
    end

    logic [WIDTH-1:0] w_st_data1;
    logic [WIDTH-1:0] w_st_data2;
    logic             w_st_busy1;
    logic             w_st_busy2;

    always_comb begin
        w_st_data1 = (rd_addr1 == '0) ? '0 : r_mem[rd_addr1];
        w_st_data2 = (rd_addr2 == '0) ? '0 : r_mem[rd_addr2];
        w_st_busy1 = (rd_addr1 == '0) ? 1'b0 : r_busy[rd_addr1];
        w_st_busy2 = (rd_addr2 == '0) ? 1'b0 : r_busy[rd_addr2];
        dbg_data   = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];
    end

`ifdef REGFILE_SB_BYPASS_EN
    logic w_byp1;
    logic w_byp2;
    logic w_byp_busy;

    // Bypass is gated by rst so reads stay 0 while reset is held.
    assign w_byp1     = rst && w_wr_act && (wr_addr == rd_addr1);
    assign w_byp2     = rst && w_wr_act && (wr_addr == rd_addr2);
    assign w_byp_busy = w_iss_act && (iss_addr == wr_addr);

    always_comb begin
        rd_data1 = w_byp1 ? wr_data    : w_st_data1;
        rd_data2 = w_byp2 ? wr_data    : w_st_data2;
        rd_busy1 = w_byp1 ? w_byp_busy : w_st_busy1;
        rd_busy2 = w_byp2 ? w_byp_busy : w_st_busy2;
    end
`else
    always_comb begin
        rd_data1 = w_st_data1;
        rd_data2 = w_st_data2;
        rd_busy1 = w_st_busy1;
        rd_busy2 = w_st_busy2;
    end
`endif

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] rd_addr1 = '0;
    logic [ADDR_W-1:0] rd_addr2 = '0;
    logic [WIDTH-1:0]  rd_data1;
    logic [WIDTH-1:0]  rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              iss_en = 1'b0;
    logic [ADDR_W-1:0] iss_addr = '0;
    logic [ADDR_W:0]   busy_cnt;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [WIDTH-1:0]  dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_cnt(busy_cnt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then move 1 time unit past it to drive/sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd5; dbg_addr = 5'd5;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        #1;
        n_cmp++; if (busy_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", busy_cnt); end
        n_cmp++; if (rd_data1 !== 32'h0) begin n_bad++; $display("FAIL reset_rd1 got %h want 0", rd_data1); end
        n_cmp++; if (rd_data2 !== 32'h0) begin n_bad++; $display("FAIL reset_rd2_nobyp got %h want 0", rd_data2); end
        n_cmp++; if (dbg_data !== 32'h0) begin n_bad++; $display("FAIL reset_dbg got %h want 0", dbg_data); end
        rd_addr1 = 5'd6;
        #1;
        n_cmp++; if (rd_busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", rd_busy1); end
        idle();
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_addr1 = 5'd5; dbg_addr = 5'd5;
        #1;
        n_cmp++; if (rd_data1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr5_data got %h want deadbeef", rd_data1); end
        n_cmp++; if (rd_busy1 !== 1'b0) begin n_bad++; $display("FAIL wr5_busy got %b want 0", rd_busy1); end
        n_cmp++; if (busy_cnt !== 6'd0) begin n_bad++; $display("FAIL wr5_cnt got %0d want 0", busy_cnt); end
        n_cmp++; if (dbg_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr5_dbg got %h want deadbeef", dbg_data); end
    endtask

    task automatic test_reg0();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        iss_en = 1'b1; iss_addr = 5'd0;
        rd_addr1 = 5'd0; dbg_addr = 5'd0;
        tick();
        idle();
        #1;
        n_cmp++; if (rd_data1 !== 32'h0) begin n_bad++; $display("FAIL r0_data got %h want 0", rd_data1); end
        n_cmp++; if (rd_busy1 !== 1'b0) begin n_bad++; $display("FAIL r0_busy got %b want 0", rd_busy1); end
        n_cmp++; if (busy_cnt !== 6'd0) begin n_bad++; $display("FAIL r0_cnt got %0d want 0", busy_cnt); end
        n_cmp++; if (dbg_data !== 32'h0) begin n_bad++; $display("FAIL r0_dbg got %h want 0", dbg_data); end
    endtask

    task automatic test_issue_count();
        logic [ADDR_W-1:0] seq [3];
        logic [ADDR_W:0]   exp [3];
        seq = '{5'd3, 5'd7, 5'd3};
        exp = '{6'd1, 6'd2, 6'd2};
        for (int i = 0; i < 3; i++) begin
            iss_en = 1'b1; iss_addr = seq[i];
            tick();
            n_cmp++; if (busy_cnt !== exp[i]) begin n_bad++; $display("FAIL iss_cnt[%0d] got %0d want %0d", i, busy_cnt, exp[i]); end
        end
        idle();
        rd_addr1 = 5'd3;
        #1;
        n_cmp++; if (rd_busy1 !== 1'b1) begin n_bad++; $display("FAIL iss3_busy got %b want 1", rd_busy1); end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        tick();
        idle();
        rd_addr2 = 5'd7;
        #1;
        n_cmp++; if (busy_cnt !== 6'd1) begin n_bad++; $display("FAIL wr7_cnt got %0d want 1", busy_cnt); end
        n_cmp++; if (rd_busy2 !== 1'b0) begin n_bad++; $display("FAIL wr7_busy got %b want 0", rd_busy2); end
        n_cmp++; if (rd_data2 !== 32'h55) begin n_bad++; $display("FAIL wr7_data got %h want 55", rd_data2); end
    endtask

    task automatic test_same_edge();
        // busy = {3}; issue 9 first.
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        // Write and issue 9 together while 9 is busy.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5;
        tick();
        idle();
        rd_addr1 = 5'd9;
        #1;
        n_cmp++; if (rd_data1 !== 32'hA5) begin n_bad++; $display("FAIL same9_data got %h want a5", rd_data1); end
        n_cmp++; if (rd_busy1 !== 1'b1) begin n_bad++; $display("FAIL same9_busy got %b want 1", rd_busy1); end
        n_cmp++; if (busy_cnt !== 6'd2) begin n_bad++; $display("FAIL same9_cnt got %0d want 2", busy_cnt); end
        // Different addresses: write 3 (busy) and issue 11.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        iss_en = 1'b1; iss_addr = 5'd11;
        tick();
        idle();
        rd_addr1 = 5'd3; rd_addr2 = 5'd11;
        #1;
        n_cmp++; if (rd_busy1 !== 1'b0) begin n_bad++; $display("FAIL diff3_busy got %b want 0", rd_busy1); end
        n_cmp++; if (rd_data1 !== 32'h33) begin n_bad++; $display("FAIL diff3_data got %h want 33", rd_data1); end
        n_cmp++; if (rd_busy2 !== 1'b1) begin n_bad++; $display("FAIL diff11_busy got %b want 1", rd_busy2); end
        n_cmp++; if (busy_cnt !== 6'd2) begin n_bad++; $display("FAIL diff_cnt got %0d want 2", busy_cnt); end
        // Write + issue on a non-busy address: becomes busy, count +1.
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC;
        iss_en = 1'b1; iss_addr = 5'd12;
        tick();
        idle();
        rd_addr1 = 5'd12;
        #1;
        n_cmp++; if (rd_busy1 !== 1'b1) begin n_bad++; $display("FAIL same12_busy got %b want 1", rd_busy1); end
        n_cmp++; if (rd_data1 !== 32'hC) begin n_bad++; $display("FAIL same12_data got %h want c", rd_data1); end
        n_cmp++; if (busy_cnt !== 6'd3) begin n_bad++; $display("FAIL same12_cnt got %0d want 3", busy_cnt); end
    endtask

    task automatic test_write_nonbusy();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77;
        tick();
        idle();
        rd_addr1 = 5'd5;
        #1;
        n_cmp++; if (rd_data1 !== 32'h77) begin n_bad++; $display("FAIL nb5_data got %h want 77", rd_data1); end
        n_cmp++; if (busy_cnt !== 6'd3) begin n_bad++; $display("FAIL nb5_cnt got %0d want 3", busy_cnt); end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_d;
        logic             exp_b;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11111111;
        tick();
        rd_addr2 = 5'd4; dbg_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0F0F0F0F;
        iss_en = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        exp_d = 32'h0F0F0F0F;
`else
        exp_d = 32'h11111111;
`endif
        #1;
        n_cmp++; if (rd_data2 !== exp_d) begin n_bad++; $display("FAIL byp_data got %h want %h", rd_data2, exp_d); end
        n_cmp++; if (rd_busy2 !== 1'b0) begin n_bad++; $display("FAIL byp_busy got %b want 0", rd_busy2); end
        n_cmp++; if (dbg_data !== 32'h11111111) begin n_bad++; $display("FAIL byp_dbg got %h want 11111111", dbg_data); end
        tick();
        n_cmp++; if (rd_data2 !== 32'h0F0F0F0F) begin n_bad++; $display("FAIL byp_after got %h want 0f0f0f0f", rd_data2); end
        // Write + issue same address: bypassed busy follows the issue.
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h22;
        iss_en = 1'b1; iss_addr = 5'd4;
`ifdef REGFILE_SB_BYPASS_EN
        exp_b = 1'b1;
`else
        exp_b = 1'b0;
`endif
        #1;
        n_cmp++; if (rd_busy2 !== exp_b) begin n_bad++; $display("FAIL byp_iss_busy got %b want %b", rd_busy2, exp_b); end
        tick();
        idle();
        #1;
        n_cmp++; if (busy_cnt !== 6'd4) begin n_bad++; $display("FAIL byp_iss_cnt got %0d want 4", busy_cnt); end
        n_cmp++; if (rd_busy2 !== 1'b1) begin n_bad++; $display("FAIL byp_iss_after got %b want 1", rd_busy2); end
    endtask

    task automatic test_reset_mid();
        // busy = {4,9,11,12}
        iss_en = 1'b1; iss_addr = 5'd1; tick();
        iss_addr = 5'd2; tick();
        iss_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h2; tick();
        wr_addr = 5'd4; wr_data = 32'h44; tick();
        idle();
        #1;
        n_cmp++; if (busy_cnt !== 6'd4) begin n_bad++; $display("FAIL mid_pre_cnt got %0d want 4", busy_cnt); end
        rst = 1'b0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd9; dbg_addr = 5'd4;
        #1;
        n_cmp++; if (busy_cnt !== 6'd0) begin n_bad++; $display("FAIL mid_cnt got %0d want 0", busy_cnt); end
        n_cmp++; if (rd_data1 !== 32'h0) begin n_bad++; $display("FAIL mid_rd1 got %h want 0", rd_data1); end
        n_cmp++; if (rd_busy2 !== 1'b0) begin n_bad++; $display("FAIL mid_busy9 got %b want 0", rd_busy2); end
        n_cmp++; if (dbg_data !== 32'h0) begin n_bad++; $display("FAIL mid_dbg got %h want 0", dbg_data); end
        tick();
        rst = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd1;
        tick();
        idle();
        rd_addr1 = 5'd1;
        #1;
        n_cmp++; if (busy_cnt !== 6'd1) begin n_bad++; $display("FAIL post_cnt got %0d want 1", busy_cnt); end
        n_cmp++; if (rd_busy1 !== 1'b1) begin n_bad++; $display("FAIL post_busy1 got %b want 1", rd_busy1); end
        n_cmp++; if (rd_busy2 !== 1'b0) begin n_bad++; $display("FAIL post_busy9 got %b want 0", rd_busy2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg0();
        test_issue_count();
        test_same_edge();
        test_write_nonbusy();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
